// File: rtl/buf_ser_pkg.sv
// Shared definitions for the buffered serializer.
//   BUF_SER_DEPTH / BUF_SER_WIDTH : default buffer geometry
//   buf_ser_state_e               : serializer control states
package buf_ser_pkg;

    localparam int BUF_SER_DEPTH = 32;
    localparam int BUF_SER_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } buf_ser_state_e;

endpackage

// File: rtl/buf_ser_mem.sv
// Entry storage for the serializer: one write port, one registered read port.
// A read and a write to the same address on the same edge return the old data.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address, sampled every rising edge
//   rd_data : registered read data (contents before that edge's write)
module buf_ser_mem #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Contents are deliberately not reset so they survive an aborted run.
    always_ff @(posedge clk) begin
        rd_data_q <= mem_q[rd_addr];
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/buf_serializer.sv
// Serializes buffer entries 0..len-1, LSB first, one bit per cycle, with no
// gap between entries.
//   clk, rst_n                  : clock, async active-low reset
//   wr_en, wr_addr, wr_data     : buffer write port (usable in any state)
//   start, len                  : kick off a run of len entries (1..DEPTH)
//   busy                        : run in progress (LOAD, SHIFT, DONE)
//   sout, sout_valid            : serial bit and its qualifier
//   done                        : one-cycle pulse after the last bit
module buf_serializer
    import buf_ser_pkg::*;
#(
    parameter int DEPTH = BUF_SER_DEPTH,
    parameter int WIDTH = BUF_SER_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic                     busy,
    output logic                     sout,
    output logic                     sout_valid,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [BW-1:0] CNT_LAST = BW'(WIDTH - 1);

    buf_ser_state_e   state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [AW:0]      len_q, len_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             byp_vld_q, byp_vld_d;
    logic [WIDTH-1:0] byp_data_q, byp_data_d;

    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] load_data;
    logic [AW:0]      nxt_idx;
    logic             last_entry;

    buf_ser_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The memory re-reads the next entry every cycle, so rd_data lags the
    // array by one write. A write that landed on the same edge as that read
    // is forwarded here, which makes the loaded value equal to the contents
    // at the start of the load cycle; a write in the load cycle itself is
    // not seen (read-before-write).
    assign load_data  = byp_vld_q ? byp_data_q : rd_data;
    assign last_entry = (({1'b0, ptr_q} + (AW+1)'(1)) == len_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        busy       = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (len != '0) && (len <= LEN_MAX)) begin
                    state_d = LOAD;
                    len_d   = len;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                busy    = 1'b1;
                shift_d = load_data;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
                sout       = shift_q[0];
                shift_d    = shift_q >> 1;
                cnt_d      = cnt_q + BW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (last_entry) begin
                        state_d = DONE;
                    end else begin
                        // Next entry goes straight in: no gap cycle.
                        ptr_d   = ptr_q + AW'(1);
                        shift_d = load_data;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read address tracks the entry after the one that will be in the shift
    // register next cycle; entry 0 while idle or about to load.
    always_comb begin
        nxt_idx = {1'b0, ptr_d} + (AW+1)'(1);
        rd_addr = '0;
        if (!(state_d inside {IDLE, LOAD}) && (nxt_idx < LEN_MAX)) begin
            rd_addr = nxt_idx[AW-1:0];
        end
        byp_vld_d  = wr_en && (wr_addr == rd_addr);
        byp_data_d = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            shift_q    <= '0;
            byp_vld_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            byp_vld_q  <= byp_vld_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: tb/tb_buf_serializer.sv
module tb_buf_serializer;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic [AW:0]      len;
    logic             busy, sout, sout_valid, done;

    buf_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; bit b; } exp_bit_t;
    exp_bit_t exp_bits[$];
    int       exp_done[$];
    bit       exp_busy[$];

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 0;

    // Reference model: buffer image plus the timing of the current run.
    logic [WIDTH-1:0] mm [DEPTH];
    bit act   = 0;
    int r_s   = 0;
    int r_len = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    // One clock of stimulus. The model works from the run timing: entry k is
    // captured from the buffer image at cycle start+1+k*WIDTH (before that
    // cycle's write) and its bit j appears at cycle start+2+k*WIDTH+j; done
    // follows the last bit and the run is over one cycle later.
    task automatic step(input bit we, input int wa, input int wd, input bit st, input int ln);
        int n, k;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = WIDTH'(wd);
        start   = st;
        len     = (AW+1)'(ln);
        n = cyc;
        if (act && n > r_s + 2 + r_len * WIDTH) act = 0;
        if (act && n >= r_s + 1) begin
            k = n - r_s - 1;
            if (k % WIDTH == 0 && k / WIDTH < r_len)
                for (int j = 0; j < WIDTH; j++) begin
                    exp_bit_t e;
                    e.cyc = r_s + 2 + k + j;
                    e.b   = mm[k / WIDTH][j];
                    exp_bits.push_back(e);
                end
        end
        exp_busy.push_back(act && n > r_s);
        if (!act && st && ln >= 1 && ln <= DEPTH) begin
            act   = 1;
            r_s   = n;
            r_len = ln;
            exp_done.push_back(n + 2 + ln * WIDTH);
        end
        if (we) mm[wa] = WIDTH'(wd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Assert reset mid-cycle and check that outputs drop without a clock.
    task automatic reset_now();
        @(posedge clk); #1;
        rst_n = 1'b0;
        wr_en = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_sout", sout, 0);
        chk("rst_sout_valid", sout_valid, 0);
        chk("rst_done", done, 0);
        act = 0;
        exp_bits.delete();
        exp_done.delete();
        exp_busy.push_back(0);
    endtask

    // Monitor: compares every cycle against the queued expectations.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_bit_t e;
            if (exp_busy.size() > 0) chk("busy", busy, exp_busy.pop_front());
            if (sout_valid) begin
                if (exp_bits.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = exp_bits.pop_front();
                    chk("bit_cycle", e.cyc, cyc);
                    chk("sout", sout, e.b);
                end
            end else begin
                chk("sout_idle_zero", sout, 0);
                if (exp_bits.size() > 0 && exp_bits[0].cyc <= cyc) begin
                    e = exp_bits.pop_front();
                    chk("missing_valid", 0, 1);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, exp_done.pop_front());
            end else if (exp_done.size() > 0 && exp_done[0] <= cyc) begin
                void'(exp_done.pop_front());
                chk("missing_done", 0, 1);
            end
        end
    end

    initial begin
        rst_n = 1'b1; wr_en = 0; wr_addr = '0; wr_data = '0; start = 0; len = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 0);
        chk("init_sout", sout, 0);
        chk("init_sout_valid", sout_valid, 0);
        chk("init_done", done, 0);
        mon_en = 1;

        // Fill the whole buffer so no unknown contents can be transmitted.
        for (int i = 0; i < DEPTH; i++) step(1, i, $urandom_range(0, 255), 0, 0);

        // Single entry A5 -> 1,0,1,0,0,1,0,1.
        step(1, 0, 8'hA5, 0, 0);
        step(0, 0, 0, 1, 1);
        idle(12);

        // Three entries, contiguous.
        step(1, 0, 8'h01, 0, 0);
        step(1, 1, 8'h80, 0, 0);
        step(1, 2, 8'hFF, 0, 0);
        step(0, 0, 0, 1, 3);
        idle(30);

        // Illegal lengths are ignored.
        step(0, 0, 0, 1, 0);
        idle(3);
        step(0, 0, 0, 1, 33);
        idle(5);

        // Write to a not-yet-loaded entry during bit 3 of entry 0, plus a
        // mid-run start that must be ignored.
        step(1, 1, 8'h00, 0, 0);
        step(0, 0, 0, 1, 2);
        idle(4);
        step(1, 1, 8'h0F, 1, 1);
        idle(25);

        // Reset at bit 5 of entry 0, then immediate restart.
        step(1, 0, 8'h3C, 0, 0);
        step(0, 0, 0, 1, 1);
        idle(6);
        reset_now();
        step(0, 0, 0, 1, 1);
        idle(12);

        // Full-length run.
        for (int i = 0; i < DEPTH; i++) step(1, i, $urandom_range(0, 255), 0, 0);
        step(0, 0, 0, 1, DEPTH);
        idle(DEPTH * WIDTH + 6);

        // Random traffic: writes anywhere at any time, starts of any length.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 3) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
                 ($urandom % 20) == 0, $urandom_range(0, DEPTH + 2));
        idle(DEPTH * WIDTH + 10);

        @(negedge clk);
        mon_en = 0;
        chk("bits_drained", exp_bits.size(), 0);
        chk("dones_drained", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
